// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART: parity encodings, FSM states
// and the frame-length helper used by both directions.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    TXS_IDLE,
    TXS_START,
    TXS_DATA,
    TXS_PARITY,
    TXS_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RXS_IDLE,
    RXS_START,
    RXS_DATA,
    RXS_PARITY,
    RXS_STOP
  } rx_state_t;

  // Serial bits per frame: start + data + optional parity + stop bits.
  function automatic int frame_len(input int data_bits, input int parity, input int stop_bits);
    return 1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Free-running bit-period counter with bit-end and mid-bit strobes; one per
// direction so TX and RX keep independent timing.
module uart_bit_timer #(
  parameter int BIT_CLKS = 609
) (
  input  logic CLK,
  input  logic RESETB,
  input  logic clear,
  input  logic enable,
  output logic bit_end,
  output logic mid_bit
);

  localparam int CW = $clog2(BIT_CLKS);
  localparam logic [CW-1:0] LAST = CW'(BIT_CLKS - 1);
  localparam logic [CW-1:0] MID  = CW'(BIT_CLKS / 2);

  logic [CW-1:0] count;

  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

  assign bit_end = enable && (count == LAST);
  assign mid_bit = enable && (count == MID);

endmodule

// File: rtl/uart_cfg.sv
// Parametrised full-duplex UART: configurable bit period, data width, parity
// and stop bits, with parity/framing error reporting and break detection.
module uart_cfg
  import uart_pkg::*;
#(
  parameter int BIT_CLKS  = 609,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 CLK,
  input  logic                 RESETB,
  output logic                 TXD,
  input  logic                 RXD,
  input  logic [DATA_BITS-1:0] TX_DATA,
  input  logic                 TX_DATA_EN,
  output logic                 TX_BUSY,
  output logic [DATA_BITS-1:0] RX_DATA,
  output logic                 RX_DATA_EN,
  output logic                 RX_PERR,
  output logic                 RX_FERR,
  output logic                 RX_BREAK,
  output logic                 RX_BUSY
);

  localparam int FRAME     = frame_len(DATA_BITS, PARITY, STOP_BITS);
  localparam int BRK_LIMIT = (FRAME + 1) * BIT_CLKS;
  localparam int BW        = $clog2(BRK_LIMIT + 1);
  localparam logic [BW-1:0] BRK_MAX  = BW'(BRK_LIMIT);
  localparam logic [BW-1:0] BRK_LAST = BW'(BRK_LIMIT - 1);
  localparam bit HAS_PAR = (PARITY != PAR_NONE);

  tx_state_t tx_state, tx_next;
  logic [DATA_BITS-1:0] tx_word;
  logic [3:0] tx_idx, tx_idx_d;
  logic tx_accept, tx_bit_end, tx_mid_unused, tx_par, txd_d, tx_busy_d;

  assign tx_accept = (tx_state == TXS_IDLE) && !TX_BUSY && TX_DATA_EN;
  assign tx_par    = (PARITY == PAR_EVEN) ? ^tx_word : ~^tx_word;

  uart_bit_timer #(.BIT_CLKS(BIT_CLKS)) u_tx_timer (
    .CLK     (CLK),
    .RESETB  (RESETB),
    .clear   (tx_accept),
    .enable  (tx_state != TXS_IDLE),
    .bit_end (tx_bit_end),
    .mid_bit (tx_mid_unused)
  );

  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) tx_state <= TXS_IDLE;
    else         tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TXS_IDLE:   if (tx_accept) tx_next = TXS_START;
      TXS_START:  if (tx_bit_end) tx_next = TXS_DATA;
      TXS_DATA:   if (tx_bit_end && tx_idx == 4'(DATA_BITS - 1))
                    tx_next = HAS_PAR ? TXS_PARITY : TXS_STOP;
      TXS_PARITY: if (tx_bit_end) tx_next = TXS_STOP;
      TXS_STOP:   if (tx_bit_end && tx_idx == 4'(STOP_BITS - 1)) tx_next = TXS_IDLE;
      default:    tx_next = TXS_IDLE;
    endcase
  end

  // TXD is registered, so the line level is computed from the upcoming state.
  always_comb begin
    tx_idx_d = tx_idx;
    if (tx_next != tx_state) tx_idx_d = '0;
    else if (tx_bit_end)     tx_idx_d = tx_idx + 1'b1;
    tx_busy_d = (tx_next != TXS_IDLE);
    case (tx_next)
      TXS_START:  txd_d = 1'b0;
      TXS_DATA:   txd_d = tx_word[tx_idx_d[2:0]];
      TXS_PARITY: txd_d = tx_par;
      default:    txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      tx_word <= '0;
      tx_idx  <= '0;
      TXD     <= 1'b1;
      TX_BUSY <= 1'b0;
    end else begin
      if (tx_accept) tx_word <= TX_DATA;
      tx_idx  <= tx_idx_d;
      TXD     <= txd_d;
      TX_BUSY <= tx_busy_d;
    end
  end

  rx_state_t rx_state, rx_next;
  logic rx_s1, rx_s2, rx_dly, rx_fall, rx_start;
  logic rx_bit_end, rx_mid, rx_take_data, rx_take_par, rx_done, rx_par_bit, rx_exp_par;
  logic [DATA_BITS-1:0] rx_shift;
  logic [3:0] rx_idx;
  logic [BW-1:0] brk_cnt;

  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      rx_s1  <= 1'b1;
      rx_s2  <= 1'b1;
      rx_dly <= 1'b1;
    end else begin
      rx_s1  <= RXD;
      rx_s2  <= rx_s1;
      rx_dly <= rx_s2;
    end
  end

  assign rx_fall    = rx_dly && !rx_s2;
  assign rx_start   = (rx_state == RXS_IDLE) && rx_fall && !RX_BREAK;
  assign rx_exp_par = (PARITY == PAR_EVEN) ? ^rx_shift : ~^rx_shift;

  uart_bit_timer #(.BIT_CLKS(BIT_CLKS)) u_rx_timer (
    .CLK     (CLK),
    .RESETB  (RESETB),
    .clear   (rx_start),
    .enable  (rx_state != RXS_IDLE),
    .bit_end (rx_bit_end),
    .mid_bit (rx_mid)
  );

  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) rx_state <= RXS_IDLE;
    else         rx_state <= rx_next;
  end

  // Leaving STOP at its midpoint re-arms the receiver half a bit early.
  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RXS_IDLE:   if (rx_start) rx_next = RXS_START;
      RXS_START:  if (rx_mid && rx_s2) rx_next = RXS_IDLE;
                  else if (rx_bit_end) rx_next = RXS_DATA;
      RXS_DATA:   if (rx_bit_end && rx_idx == 4'(DATA_BITS - 1))
                    rx_next = HAS_PAR ? RXS_PARITY : RXS_STOP;
      RXS_PARITY: if (rx_bit_end) rx_next = RXS_STOP;
      RXS_STOP:   if (rx_mid) rx_next = RXS_IDLE;
      default:    rx_next = RXS_IDLE;
    endcase
  end

  always_comb begin
    RX_BUSY      = (rx_state != RXS_IDLE);
    rx_take_data = (rx_state == RXS_DATA) && rx_mid;
    rx_take_par  = (rx_state == RXS_PARITY) && rx_mid;
    rx_done      = (rx_state == RXS_STOP) && rx_mid;
  end

  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      rx_shift   <= '0;
      rx_par_bit <= 1'b0;
      rx_idx     <= '0;
      RX_DATA    <= '0;
      RX_DATA_EN <= 1'b0;
      RX_PERR    <= 1'b0;
      RX_FERR    <= 1'b0;
    end else begin
      RX_DATA_EN <= rx_done;
      if (rx_state != RXS_DATA) rx_idx <= '0;
      else if (rx_bit_end)      rx_idx <= rx_idx + 1'b1;
      if (rx_take_data) rx_shift <= {rx_s2, rx_shift[DATA_BITS-1:1]};
      if (rx_take_par)  rx_par_bit <= rx_s2;
      if (rx_done) begin
        RX_DATA <= rx_shift;
        RX_PERR <= HAS_PAR && (rx_par_bit != rx_exp_par);
        RX_FERR <= !rx_s2;
      end
    end
  end

  // Break: saturating run-length of low synchronised samples.
  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      brk_cnt  <= '0;
      RX_BREAK <= 1'b0;
    end else if (rx_s2) begin
      brk_cnt  <= '0;
      RX_BREAK <= 1'b0;
    end else if (brk_cnt != BRK_MAX) begin
      brk_cnt <= brk_cnt + 1'b1;
      if (brk_cnt == BRK_LAST) RX_BREAK <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_cfg.sv
// Scoreboard bench for uart_cfg: three instances (8N1, 8O1, 7E2 looped back)
// driven with directed and random frames against a frame-level model.
module tb_uart_cfg;

  localparam int BC = 16;
  localparam int DBITS [3] = '{8, 8, 7};
  localparam int PARS  [3] = '{0, 1, 2};
  localparam int FL    [3] = '{10, 11, 11};

  logic CLK;
  logic RESETB;
  logic txd [3];
  logic tx_busy [3];
  logic tx_en [3];
  logic [7:0] tx_data [3];
  logic rx_busy [3];
  logic rx_en [3];
  logic rx_perr [3];
  logic rx_ferr [3];
  logic rx_break [3];
  logic [7:0] rx_data [3];
  logic [7:0] rx_data0, rx_data1;
  logic [6:0] rx_data2;
  logic drv_rxd [2];
  logic rxd0;
  bit loop0;

  int checks = 0;
  int errors = 0;
  int edge_no = 0;
  int tx_free [3];
  bit tx_active [3];
  logic [15:0] txq [3][$];
  logic [9:0] rxq [3][$];

  assign rxd0 = loop0 ? txd[0] : drv_rxd[0];
  assign rx_data[0] = rx_data0;
  assign rx_data[1] = rx_data1;
  assign rx_data[2] = {1'b0, rx_data2};

  uart_cfg #(.BIT_CLKS(BC), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .CLK(CLK), .RESETB(RESETB), .TXD(txd[0]), .RXD(rxd0),
    .TX_DATA(tx_data[0]), .TX_DATA_EN(tx_en[0]), .TX_BUSY(tx_busy[0]),
    .RX_DATA(rx_data0), .RX_DATA_EN(rx_en[0]), .RX_PERR(rx_perr[0]),
    .RX_FERR(rx_ferr[0]), .RX_BREAK(rx_break[0]), .RX_BUSY(rx_busy[0]));

  uart_cfg #(.BIT_CLKS(BC), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8o1 (
    .CLK(CLK), .RESETB(RESETB), .TXD(txd[1]), .RXD(drv_rxd[1]),
    .TX_DATA(tx_data[1]), .TX_DATA_EN(tx_en[1]), .TX_BUSY(tx_busy[1]),
    .RX_DATA(rx_data1), .RX_DATA_EN(rx_en[1]), .RX_PERR(rx_perr[1]),
    .RX_FERR(rx_ferr[1]), .RX_BREAK(rx_break[1]), .RX_BUSY(rx_busy[1]));

  uart_cfg #(.BIT_CLKS(BC), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_7e2 (
    .CLK(CLK), .RESETB(RESETB), .TXD(txd[2]), .RXD(txd[2]),
    .TX_DATA(tx_data[2][6:0]), .TX_DATA_EN(tx_en[2]), .TX_BUSY(tx_busy[2]),
    .RX_DATA(rx_data2), .RX_DATA_EN(rx_en[2]), .RX_PERR(rx_perr[2]),
    .RX_FERR(rx_ferr[2]), .RX_BREAK(rx_break[2]), .RX_BUSY(rx_busy[2]));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) edge_no <= edge_no + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  function automatic logic [7:0] data_mask(input int i);
    return 8'((1 << DBITS[i]) - 1);
  endfunction

  // Line levels of one frame, index 0 first on the wire; unused tail stays high.
  function automatic logic [15:0] frame_bits(input int i, input logic [7:0] d,
                                             input bit bad_par, input bit stop_low);
    logic [15:0] b;
    int p;
    int ones;
    logic pb;
    b = '1;
    b[0] = 1'b0;
    p = 1;
    ones = 0;
    for (int k = 0; k < DBITS[i]; k++) begin
      b[p] = d[k];
      if (d[k]) ones++;
      p++;
    end
    if (PARS[i] != 0) begin
      pb = (ones % 2 == 1);
      if (PARS[i] == 1) pb = !pb;
      b[p] = pb ^ bad_par;
      p++;
    end
    b[p] = !stop_low;
    return b;
  endfunction

  // Strobe a transmit request; the model decides whether it is accepted.
  task automatic applyStimulus(input int i, input logic [7:0] d);
    logic [7:0] m;
    m = d & data_mask(i);
    tx_data[i] = m;
    tx_en[i] = 1'b1;
    if (edge_no + 1 >= tx_free[i]) begin
      txq[i].push_back(frame_bits(i, m, 1'b0, 1'b0));
      tx_free[i] = edge_no + 1 + FL[i] * BC + 1;
      if (i == 2 || (i == 0 && loop0)) rxq[i].push_back({2'b00, m});
    end
    step(1);
    tx_en[i] = 1'b0;
  endtask

  task automatic wait_tx_idle(input int i);
    while (edge_no + 1 < tx_free[i]) step(1);
  endtask

  task automatic drive_rx_frame(input int i, input logic [7:0] d, input bit bad_par, input bit stop_low);
    logic [15:0] b;
    b = frame_bits(i, d, bad_par, stop_low);
    rxq[i].push_back({bad_par, stop_low, d & data_mask(i)});
    for (int k = 0; k < FL[i]; k++) begin
      drv_rxd[i] = b[k];
      step(BC);
    end
    drv_rxd[i] = 1'b1;
    step(4);
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_mon
    initial begin : tx_mon
      int cyc;
      int bad;
      logic [15:0] exp_bits;
      cyc = 0;
      bad = 0;
      exp_bits = '1;
      forever begin
        @(negedge CLK);
        if (RESETB) begin
          if (tx_busy[g] && !tx_active[g]) begin
            checkOutput($sformatf("tx_expected%0d", g), 32'(txq[g].size() != 0), 1);
            exp_bits = (txq[g].size() != 0) ? txq[g].pop_front() : 16'h0000;
            tx_active[g] = 1'b1;
            cyc = 0;
            bad = 0;
          end
          if (tx_active[g]) begin
            if (tx_busy[g]) begin
              if (txd[g] !== exp_bits[cyc / BC]) bad++;
              cyc++;
            end else begin
              checkOutput($sformatf("tx_bits%0d", g), bad, 0);
              checkOutput($sformatf("tx_busy_len%0d", g), cyc, FL[g] * BC);
              tx_active[g] = 1'b0;
            end
          end
        end
      end
    end

    initial begin : rx_mon
      logic [9:0] e;
      forever begin
        @(negedge CLK);
        if (RESETB && rx_en[g]) begin
          checkOutput($sformatf("rx_expected%0d", g), 32'(rxq[g].size() != 0), 1);
          if (rxq[g].size() != 0) begin
            e = rxq[g].pop_front();
            checkOutput($sformatf("rx_word%0d", g), {rx_perr[g], rx_ferr[g], rx_data[g]}, e);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    errors++;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : main
    RESETB = 1'b0;
    loop0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tx_en[i] = 1'b0;
      tx_data[i] = 8'h00;
      tx_free[i] = 0;
      tx_active[i] = 1'b0;
    end
    drv_rxd[0] = 1'b1;
    drv_rxd[1] = 1'b1;
    step(3);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("reset_txd%0d", i), txd[i], 1);
      checkOutput($sformatf("reset_outs%0d", i),
                  {tx_busy[i], rx_busy[i], rx_en[i], rx_perr[i], rx_ferr[i], rx_break[i], rx_data[i]}, 0);
    end
    RESETB = 1'b1;
    step(2);

    $display("[TB] 8N1 transmit 0x55, ignored strobe, back-to-back frames");
    applyStimulus(0, 8'h55);
    step(48);
    checkOutput("tx_busy_mid", tx_busy[0], 1);
    applyStimulus(0, 8'hAA);
    for (int k = 0; k < 4; k++) begin
      wait_tx_idle(0);
      applyStimulus(0, 8'($urandom));
    end
    wait_tx_idle(0);
    step(4);

    $display("[TB] 7E2 loopback and 8O1 transmit in parallel");
    fork
      begin
        applyStimulus(2, 8'h07);
        for (int k = 0; k < 3; k++) begin
          wait_tx_idle(2);
          applyStimulus(2, 8'($urandom));
        end
        wait_tx_idle(2);
      end
      begin
        for (int k = 0; k < 3; k++) begin
          wait_tx_idle(1);
          applyStimulus(1, 8'($urandom));
        end
        wait_tx_idle(1);
      end
    join
    step(20);

    $display("[TB] 8O1 receive with parity and framing errors");
    fork
      begin
        drive_rx_frame(1, 8'hA3, 1'b1, 1'b0);
        drive_rx_frame(1, 8'hA3, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++)
          drive_rx_frame(1, 8'($urandom), 1'($urandom), 1'($urandom));
      end
      begin
        for (int k = 0; k < 3; k++) begin
          wait_tx_idle(1);
          applyStimulus(1, 8'($urandom));
        end
      end
    join
    wait_tx_idle(1);
    step(10);

    $display("[TB] start-bit glitch then valid frame");
    drv_rxd[1] = 1'b0;
    step(5);
    drv_rxd[1] = 1'b1;
    checkOutput("glitch_busy_set", rx_busy[1], 1);
    step(15);
    checkOutput("glitch_busy_clr", rx_busy[1], 0);
    drive_rx_frame(1, 8'h3C, 1'b0, 1'b0);
    step(10);

    $display("[TB] 8N1 break detection");
    rxq[0].push_back({1'b0, 1'b1, 8'h00});
    drv_rxd[0] = 1'b0;
    step(174);
    checkOutput("break_early", rx_break[0], 0);
    step(7);
    checkOutput("break_set", rx_break[0], 1);
    step(9);
    checkOutput("break_rx_idle", rx_busy[0], 0);
    step(10);
    drv_rxd[0] = 1'b1;
    step(6);
    checkOutput("break_clr", rx_break[0], 0);
    step(10);

    $display("[TB] reset mid-frame then 0xF0 loopback");
    loop0 = 1'b1;
    fork
      applyStimulus(0, 8'($urandom));
      applyStimulus(2, 8'($urandom));
    join
    drv_rxd[1] = 1'b0;
    step(60);
    checkOutput("pre_reset_txbusy", tx_busy[0], 1);
    checkOutput("pre_reset_rxbusy", rx_busy[1], 1);
    #2;
    RESETB = 1'b0;
    for (int i = 0; i < 3; i++) begin
      txq[i].delete();
      rxq[i].delete();
      tx_active[i] = 1'b0;
      tx_free[i] = 0;
    end
    #1;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("abort_txd%0d", i), txd[i], 1);
      checkOutput($sformatf("abort_outs%0d", i), {tx_busy[i], rx_busy[i], rx_en[i]}, 0);
    end
    step(1);
    drv_rxd[1] = 1'b1;
    step(3);
    RESETB = 1'b1;
    step(2);
    applyStimulus(0, 8'hF0);
    wait_tx_idle(0);
    step(30);

    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("rxq_drained%0d", i), rxq[i].size(), 0);
      checkOutput($sformatf("txq_drained%0d", i), txq[i].size(), 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
